// File: rtl/chr_bg_pkg.sv
// chr_bg_pkg: shared definitions for the character background writers.
//   DEFAULT_CHR_SIZE_BITS : default log2 of the name map side
//   CHR_ADDR_BITS         : name address width for the default map size
//   state_e               : command FSM states (IDLE / RUN / FIN)
//   map_addr()            : composes a zero-extended map address {row, col}
package chr_bg_pkg;

  localparam int DEFAULT_CHR_SIZE_BITS = 6;
  localparam int CHR_ADDR_BITS         = 2 * DEFAULT_CHR_SIZE_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Both coordinates are masked to size_bits, so callers may hand in
  // untruncated sums and still get a wrapped address.
  function automatic logic [31:0] map_addr(input logic [31:0] row,
                                           input logic [31:0] col,
                                           input int          size_bits);
    logic [31:0] mask;
    mask = (32'd1 << size_bits) - 32'd1;
    return ((row & mask) << size_bits) | (col & mask);
  endfunction

endpackage

// File: rtl/rect_scan_counter.sv
// rect_scan_counter: row-major column/row scan over a rectangle.
//   clk, reset      : clock and synchronous active-high reset
//   clear           : restart the scan at (0,0)
//   step            : advance one position (col first, then row)
//   col_max/row_max : last column / last row index (width-1, height-1)
//   col, row        : current position
//   last            : current position is the final one of the rectangle
module rect_scan_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         step,
  input  logic [W-1:0] col_max,
  input  logic [W-1:0] row_max,
  output logic [W-1:0] col,
  output logic [W-1:0] row,
  output logic         last
);

  logic [W-1:0] col_q, col_d;
  logic [W-1:0] row_q, row_d;

  // Next position: clear has priority over step.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = {W{1'b0}};
      row_d = {W{1'b0}};
    end else if (step) begin
      if (col_q == col_max) begin
        col_d = {W{1'b0}};
        row_d = row_q + {{(W-1){1'b0}}, 1'b1};
      end else begin
        col_d = col_q + {{(W-1){1'b0}}, 1'b1};
        row_d = row_q;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= {W{1'b0}};
      row_q <= {W{1'b0}};
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = (col_q == col_max) && (row_q == row_max);

endmodule

// File: rtl/chr_bg_rect_writer.sv
// chr_bg_rect_writer: fills a wrapped rectangle of the character name map
// through the renderer's write port, one name per clock.
//   clk, reset           : write clock, synchronous active-high reset
//   start, mode          : command strobe (IDLE only); 1 = fill, 0 = stream
//   x0, y0, w, h         : rectangle origin and size (w/h saturate to map side)
//   fill_value           : name used in fill mode
//   s_data/s_valid/s_ready : name stream handshake (stream mode)
//   chr_address/chr_din/chr_we : registered name RAM write port
//   busy, done           : command in progress / one-cycle completion pulse
module chr_bg_rect_writer
  import chr_bg_pkg::*;
#(
  parameter int CHR_SIZE_BITS = DEFAULT_CHR_SIZE_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      mode,
  input  logic [CHR_SIZE_BITS-1:0]  x0,
  input  logic [CHR_SIZE_BITS-1:0]  y0,
  input  logic [CHR_SIZE_BITS:0]    w,
  input  logic [CHR_SIZE_BITS:0]    h,
  input  logic [7:0]                fill_value,
  input  logic [7:0]                s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic signed [31:0]        chr_address,
  output logic signed [7:0]         chr_din,
  output logic                      chr_we,
  output logic                      busy,
  output logic                      done
);

  localparam int S = CHR_SIZE_BITS;
  localparam logic [S:0] DIM_MAX = {1'b1, {S{1'b0}}};
  localparam logic [S:0] DIM_ONE = {{S{1'b0}}, 1'b1};

  state_e       state_q;
  logic         mode_q;
  logic [S-1:0] x0_q, y0_q;
  logic [S-1:0] col_max_q, row_max_q;
  logic [7:0]   fill_q;
  logic [31:0]  addr_q, addr_d;
  logic [7:0]   din_q, din_d;
  logic         we_q;

  logic [S:0]   w_sat_s, h_sat_s;
  logic [S-1:0] col_s, row_s;
  logic [S-1:0] x_sum_s, y_sum_s;
  logic         last_s, beat_s, clear_s, ready_s;

  function automatic logic [S:0] sat_dim(input logic [S:0] v);
    if (v > DIM_MAX) begin
      return DIM_MAX;
    end else begin
      return v;
    end
  endfunction

  assign w_sat_s = sat_dim(w);
  assign h_sat_s = sat_dim(h);

  rect_scan_counter #(.W(S)) u_scan (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_s),
    .step    (beat_s),
    .col_max (col_max_q),
    .row_max (row_max_q),
    .col     (col_s),
    .row     (row_s),
    .last    (last_s)
  );

  // Beat detection and the address/data a beat would write. The sums are
  // S bits wide, so the map wraps without extra logic.
  always_comb begin
    ready_s = (state_q == ST_RUN) && !mode_q;
    beat_s  = (state_q == ST_RUN) && (mode_q || (s_valid && ready_s));
    clear_s = (state_q == ST_IDLE) && start;
    x_sum_s = x0_q + col_s;
    y_sum_s = y0_q + row_s;
    addr_d  = map_addr(32'(y_sum_s), 32'(x_sum_s), S);
    if (mode_q) begin
      din_d = fill_q;
    end else begin
      din_d = s_data;
    end
  end

  // Command FSM, parameter latches and write-port registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      x0_q      <= {S{1'b0}};
      y0_q      <= {S{1'b0}};
      col_max_q <= {S{1'b0}};
      row_max_q <= {S{1'b0}};
      fill_q    <= 8'd0;
      addr_q    <= 32'd0;
      din_q     <= 8'd0;
      we_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          we_q <= 1'b0;
          if (start) begin
            mode_q    <= mode;
            x0_q      <= x0;
            y0_q      <= y0;
            fill_q    <= fill_value;
            // Size minus one; a size of 2^S maps to all-ones. Zero sizes
            // never reach RUN, so their wrapped value is irrelevant.
            col_max_q <= S'(w_sat_s - DIM_ONE);
            row_max_q <= S'(h_sat_s - DIM_ONE);
            if ((w_sat_s == {(S+1){1'b0}}) || (h_sat_s == {(S+1){1'b0}})) begin
              state_q <= ST_FIN;
            end else begin
              state_q <= ST_RUN;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (beat_s) begin
            addr_q <= addr_d;
            din_q  <= din_d;
            we_q   <= 1'b1;
            if (last_s) begin
              state_q <= ST_FIN;
            end else begin
              state_q <= ST_RUN;
            end
          end else begin
            we_q <= 1'b0;
          end
        end
        ST_FIN: begin
          we_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          we_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready     = ready_s;
  assign chr_address = $signed(addr_q);
  assign chr_din     = $signed(din_q);
  assign chr_we      = we_q;
  assign busy        = (state_q == ST_RUN) || (state_q == ST_FIN);
  assign done        = (state_q == ST_FIN);

endmodule

// File: tb/tb_chr_bg_rect_writer.sv
// Directed self-checking bench for chr_bg_rect_writer (CHR_SIZE_BITS = 6).
module tb_chr_bg_rect_writer;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [5:0]        x0 = 6'd0;
  logic [5:0]        y0 = 6'd0;
  logic [6:0]        w = 7'd0;
  logic [6:0]        h = 7'd0;
  logic [7:0]        fill_value = 8'd0;
  logic [7:0]        s_data = 8'd0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic signed [31:0] chr_address;
  logic signed [7:0] chr_din;
  logic              chr_we;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;
  int we_count = 0;
  int done_count = 0;

  chr_bg_rect_writer #(.CHR_SIZE_BITS(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .x0          (x0),
    .y0          (y0),
    .w           (w),
    .h           (h),
    .fill_value  (fill_value),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .chr_address (chr_address),
    .chr_din     (chr_din),
    .chr_we      (chr_we),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Count writes and done pulses as seen at each active edge.
  always @(posedge clk) begin
    if (chr_we === 1'b1) we_count <= we_count + 1;
    if (done === 1'b1) done_count <= done_count + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a command for one edge (edge N); returns just after edge N.
  task automatic do_start(input logic m, input logic [5:0] x, input logic [5:0] y,
                          input logic [6:0] ww, input logic [6:0] hh, input logic [7:0] fv);
    @(negedge clk);
    mode = m; x0 = x; y0 = y; w = ww; h = hh; fill_value = fv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    int wc0;
    int dc0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_we",    {31'd0, chr_we}, 32'd0);
    check_eq("rst_addr",  chr_address, 32'd0);
    check_eq("rst_din",   {24'd0, chr_din}, 32'd0);
    check_eq("rst_busy",  {31'd0, busy}, 32'd0);
    check_eq("rst_done",  {31'd0, done}, 32'd0);
    check_eq("rst_ready", {31'd0, s_ready}, 32'd0);
    reset = 1'b0;

    // Fill at (3,5), 2x2, value 0x41
    do_start(1'b1, 6'd3, 6'd5, 7'd2, 7'd2, 8'h41);
    @(negedge clk);
    check_eq("fill_busy_n1", {31'd0, busy}, 32'd1);
    check_eq("fill_we_n1",   {31'd0, chr_we}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_a;
      exp_a = (i == 0) ? 32'h143 : (i == 1) ? 32'h144 : (i == 2) ? 32'h183 : 32'h184;
      @(negedge clk);
      check_eq("fill_we",   {31'd0, chr_we}, 32'd1);
      check_eq("fill_addr", chr_address, exp_a);
      check_eq("fill_din",  {24'd0, chr_din}, 32'h41);
      check_eq("fill_done", {31'd0, done}, (i == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check_eq("fill_busy_end", {31'd0, busy}, 32'd0);
    check_eq("fill_we_end",   {31'd0, chr_we}, 32'd0);

    // Stream with wrap at (63,63), 2x2, valid held high
    do_start(1'b0, 6'd63, 6'd63, 7'd2, 7'd2, 8'h00);
    @(negedge clk);
    check_eq("wrap_ready", {31'd0, s_ready}, 32'd1);
    s_valid = 1'b1; s_data = 8'd1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_a;
      exp_a = (i == 0) ? 32'd4095 : (i == 1) ? 32'd4032 : (i == 2) ? 32'd63 : 32'd0;
      @(negedge clk);
      check_eq("wrap_we",   {31'd0, chr_we}, 32'd1);
      check_eq("wrap_addr", chr_address, exp_a);
      check_eq("wrap_din",  {24'd0, chr_din}, 32'(i + 1));
      check_eq("wrap_done", {31'd0, done}, (i == 3) ? 32'd1 : 32'd0);
      if (i < 3) s_data = 8'(i + 2);
      else begin
        check_eq("wrap_ready_fin", {31'd0, s_ready}, 32'd0);
        s_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("wrap_busy_end", {31'd0, busy}, 32'd0);

    // Backpressure: stream 4x1 at (10,20), valid toggling
    wc0 = we_count;
    do_start(1'b0, 6'd10, 6'd20, 7'd4, 7'd1, 8'h00);
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'hA0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("bp_we",   {31'd0, chr_we}, 32'd1);
      check_eq("bp_addr", chr_address, 32'(1290 + i));
      check_eq("bp_din",  {24'd0, chr_din}, 32'(8'hA0 + i));
      check_eq("bp_done", {31'd0, done}, (i == 3) ? 32'd1 : 32'd0);
      s_valid = 1'b0;
      if (i < 3) begin
        @(negedge clk);
        check_eq("bp_gap_we",   {31'd0, chr_we}, 32'd0);
        check_eq("bp_gap_done", {31'd0, done}, 32'd0);
        s_valid = 1'b1; s_data = 8'(8'hA0 + i + 1);
      end
    end
    @(negedge clk);
    check_eq("bp_busy_end", {31'd0, busy}, 32'd0);
    check_eq("bp_writes",   32'(we_count - wc0), 32'd4);

    // Empty rectangle: w=0, h=7
    wc0 = we_count;
    do_start(1'b1, 6'd1, 6'd2, 7'd0, 7'd7, 8'h11);
    @(negedge clk);
    check_eq("empty_done_n1", {31'd0, done}, 32'd1);
    check_eq("empty_busy_n1", {31'd0, busy}, 32'd1);
    check_eq("empty_we_n1",   {31'd0, chr_we}, 32'd0);
    @(negedge clk);
    check_eq("empty_busy_n2", {31'd0, busy}, 32'd0);
    check_eq("empty_done_n2", {31'd0, done}, 32'd0);
    check_eq("empty_writes",  32'(we_count - wc0), 32'd0);

    // Width saturation: w=100 -> 64 names across row 2
    do_start(1'b1, 6'd0, 6'd2, 7'd100, 7'd1, 8'h7F);
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check_eq("sat_addr", chr_address, 32'(128 + i));
      check_eq("sat_done", {31'd0, done}, (i == 63) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check_eq("sat_we_end",   {31'd0, chr_we}, 32'd0);
    check_eq("sat_busy_end", {31'd0, busy}, 32'd0);

    // Reset mid-command after the 3rd write of a 4x4 fill
    wc0 = we_count;
    dc0 = done_count;
    do_start(1'b1, 6'd0, 6'd0, 7'd4, 7'd4, 8'h55);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("mid_addr", chr_address, 32'(i));
    end
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_we",    {31'd0, chr_we}, 32'd0);
    check_eq("mid_busy",  {31'd0, busy}, 32'd0);
    check_eq("mid_ready", {31'd0, s_ready}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_writes", 32'(we_count - wc0), 32'd3);
    check_eq("mid_nodone", 32'(done_count - dc0), 32'd0);
    do_start(1'b1, 6'd1, 6'd1, 7'd1, 7'd1, 8'h33);
    @(negedge clk);
    check_eq("post_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq("post_we",   {31'd0, chr_we}, 32'd1);
    check_eq("post_addr", chr_address, 32'd65);
    check_eq("post_din",  {24'd0, chr_din}, 32'h33);
    check_eq("post_done", {31'd0, done}, 32'd1);

    // Start while busy: second start with x0=40 is ignored
    do_start(1'b1, 6'd8, 6'd0, 7'd3, 7'd1, 8'h22);
    @(negedge clk);
    start = 1'b1; x0 = 6'd40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      check_eq("sb_addr", chr_address, 32'(8 + i));
      check_eq("sb_din",  {24'd0, chr_din}, 32'h22);
    end
    @(negedge clk);
    check_eq("sb_busy_end", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_eq("sb_we_idle", {31'd0, chr_we}, 32'd0);

    // Reset and start in the same cycle: command dropped
    @(negedge clk);
    reset = 1'b1; start = 1'b1; mode = 1'b1; w = 7'd1; h = 7'd1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check_eq("rs_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_eq("rs_busy2", {31'd0, busy}, 32'd0);
    check_eq("rs_we",    {31'd0, chr_we}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
